dco_fll_ctrl: RTL

DCO_FLL_CTRL -- requirements
Module: dco_fll_ctrl

---
 rtl/dco_fll_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dco_fll_ctrl.sv
// Frequency-locked-loop controller: counts DCO rising edges over a fixed clk window
// and nudges the DCO code one step per window toward the target edge count.
module dco_fll_ctrl #(
  parameter int         WINDOW    = 256,
  parameter int         TOL       = 1,
  parameter int         LOCK_N    = 4,
  parameter logic [7:0] INIT_CODE = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] target,
  input  logic       dco_in,
  output logic [7:0] dco_code,
  output logic [7:0] count,
  output logic       meas_valid,
  output logic       locked
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int LW = (LOCK_N > 0) ? $clog2(LOCK_N + 1) : 1;

  localparam logic [WW-1:0]      WIN_LAST = WW'(WINDOW - 1);
  localparam logic [LW-1:0]      LOCK_MAX = LW'(LOCK_N);
  localparam logic signed [9:0]  TOL_S    = 10'(TOL);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  state_t         state;
  logic [WW-1:0]  win_cnt;
  logic [8:0]     edge_cnt;
  logic [LW-1:0]  lock_cnt;

  logic           dco_p0;
  logic           dco_p1;
  logic           dco_p2;
  logic           rise_det;

  logic signed [9:0] count_new_s;
  logic signed [9:0] target_s;
  logic              too_slow;
  logic              too_fast;
  logic [LW-1:0]     lock_next;

  function automatic logic [8:0] sat_inc_edges(input logic [8:0] v);
    return (v >= 9'd255) ? 9'd255 : v + 9'd1;
  endfunction

  function automatic logic [7:0] sat_inc_code(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec_code(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

  function automatic logic [LW-1:0] sat_inc_lock(input logic [LW-1:0] v);
    return (v >= LOCK_MAX) ? LOCK_MAX : v + 1'b1;
  endfunction

  // Stage p0/p1: two-flop synchroniser; stage p2: delayed copy for rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dco_p0 <= 1'b0;
      dco_p1 <= 1'b0;
      dco_p2 <= 1'b0;
    end else begin
      dco_p0 <= dco_in;
      dco_p1 <= dco_p0;
      dco_p2 <= dco_p1;
    end
  end

  assign rise_det = dco_p1 & ~dco_p2;

  // Window verdict, evaluated against the live target so a change lands at the next UPDATE
  always_comb begin
    count_new_s = $signed({2'b00, edge_cnt[7:0]});
    target_s    = $signed({2'b00, target});
    too_slow    = count_new_s < (target_s - TOL_S);
    too_fast    = count_new_s > (target_s + TOL_S);
    lock_next   = sat_inc_lock(lock_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      lock_cnt   <= '0;
      dco_code   <= INIT_CODE;
      count      <= 8'h00;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          win_cnt  <= '0;
          edge_cnt <= '0;
          lock_cnt <= '0;
          locked   <= 1'b0;
          if (ena) state <= MEASURE;
        end

        MEASURE: begin
          if (!ena) begin
            state    <= IDLE;
            win_cnt  <= '0;
            edge_cnt <= '0;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end else begin
            if (rise_det) edge_cnt <= sat_inc_edges(edge_cnt);
            if (win_cnt == WIN_LAST) state <= UPDATE;
            else                     win_cnt <= win_cnt + 1'b1;
          end
        end

        UPDATE: begin
          win_cnt  <= '0;
          edge_cnt <= '0;
          if (!ena) begin
            state    <= IDLE;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end else begin
            state      <= MEASURE;
            count      <= edge_cnt[7:0];
            meas_valid <= 1'b1;
            if (too_slow) begin
              dco_code <= sat_inc_code(dco_code);
              lock_cnt <= '0;
              locked   <= 1'b0;
            end else if (too_fast) begin
              dco_code <= sat_dec_code(dco_code);
              lock_cnt <= '0;
              locked   <= 1'b0;
            end else begin
              lock_cnt <= lock_next;
              locked   <= (lock_next == LOCK_MAX);
            end
          end
        end

        default: begin
          state    <= IDLE;
          win_cnt  <= '0;
          edge_cnt <= '0;
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

endmodule
